muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   EX-stage controller for HI/LO multiply/divide ops. Accepts one op per instruction and runs a
//   32-step restoring divider. Holds the pipeline through the hazard unit's stall-request input
//   while the op runs, and returns {hi,lo} with a one-cycle done pulse. An exception flush
//   cancels an op in flight.
// PARAMETERS
//   MUL_LAT      2              cycles a sequenced multiply occupies (only with MULDIV_MUL_SEQ_EN); >=1
//   DIVZ_LO      32'hFFFF_FFFF  LO value returned on divide-by-zero
// PORTS
//   clk        in   1   clock
//   resetn     in   1   asynchronous reset, active low
//   start_i    in   1   EX holds valid DIV/DIVU/MULT/MULTU
//   op_i       in   2   00 DIV, 01 DIVU, 10 MULT, 11 MULTU (`MD_OP_* in defines.h)
//   a_i        in   32  rs operand (dividend / multiplicand)
//   b_i        in   32  rt operand (divisor / multiplier)
//   stall_i    in   1   pipeline frozen by another source (e.g. stallreq_from_mem)
//   cancel_i   in   1   exception flush (excepttypeM != 0)
//   stall_o    out  1   stall request to hazard unit
//   busy_o     out  1   FSM not IDLE
//   done_o     out  1   result valid this cycle; EX writes hilo
//   hi_o       out  32  remainder / product[63:32]
//   lo_o       out  32  quotient / product[31:0]
// BEHAVIOUR
//   Reset: state=IDLE; stall_o=0, busy_o=0, done_o=0, hi_o=0, lo_o=0; step counter 0.
//   FSM: IDLE -> DIV_RUN | MUL_RUN -> DONE -> IDLE.
//   IDLE: start_i & ~cancel_i & div op: latch |a|,|b| and the signs; go to DIV_RUN. stall_o=1
//     combinationally in the accept cycle.
//   DIV_RUN: one quotient bit per cycle over 32 cycles (counter 0..31). Then DONE. stall_o=1.
//     Start accepted in cycle N gives done_o in cycle N+33.
//   Signed fix-up (DIV): quotient negated iff a[31]^b[31]; remainder takes the sign of a.
//     0x80000000 / -1 gives lo=0x80000000, hi=0, with no trap.
//   b_i==0: skip DIV_RUN and go to DONE next cycle; lo=DIVZ_LO, hi=a_i (raw operand).
//   DONE: done_o=1, stall_o=0, hi_o/lo_o valid.
//     Stays in DONE while stall_i=1. Only then does a still-asserted start_i belong to the
//     same instruction, so it must not restart the op.
//     Leaves for IDLE when stall_i=0. start_i is ignored in DONE.
//   hi_o/lo_o hold their last result until the next DONE.
//   cancel_i in any state: IDLE next cycle; done_o not asserted; hi_o/lo_o unchanged.
//     cancel_i has priority over start_i in the same cycle.
//     A cancel arriving in DONE suppresses done_o in that cycle (done_o = DONE & ~cancel_i).
//   busy_o = (state != IDLE).
//   Reset in mid-operation discards the op immediately; all outputs return to reset values.
// CONFIGURATION
//   MULDIV_MUL_SEQ_EN defined:
//     MULT/MULTU accepted like a divide; MUL_RUN lasts MUL_LAT cycles with stall_o=1; then DONE.
//     The product uses a registered 32x32 multiplier.
//   MULDIV_MUL_SEQ_EN undefined:
//     MULT/MULTU complete in the accept cycle: done_o=1, stall_o=0, combinational product on
//     hi_o/lo_o that same cycle (registered for hold). The FSM stays IDLE.
// STRUCTURE
//   defines.h: `MD_OP_DIV/DIVU/MULT/MULTU encodings, FSM state encodings, `MD_DIV_STEPS=32.
//   Sub-module div_iter_core: restoring shift/subtract datapath.
//     Inputs: load, step, |a|, |b|. Outputs: quotient and remainder magnitudes.
//   The sequencer owns the FSM, counter, sign fix-up, cancel and stall logic.
// TESTING
//   1. DIVU a=100,b=7, start at cycle N:
//      stall_o high N..N+32; done_o only at N+33; lo=14, hi=2.
//   2. DIV a=-7 (0xFFFFFFF9), b=2:
//      lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); also 0x80000000/-1 -> lo=0x80000000, hi=0.
//   3. DIV a=5, b=0: done_o at N+1; lo=0xFFFFFFFF, hi=5.
//   4. DIVU started, cancel_i pulsed at step 10:
//      next cycle busy_o=0, stall_o=0; no done_o; hi/lo keep prior values.
//      A new start then completes correctly.
//   5. stall_i=1 for 3 cycles during DONE, start_i held:
//      done_o held 4 cycles, no restart, one result.
//   6. MULT 0xFFFFFFFF*2:
//      undefined macro: same-cycle done_o, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//      MULDIV_MUL_SEQ_EN defined: stall_o high MUL_LAT+1 cycles, then done_o with the same values.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared op encodings, FSM states and arithmetic helpers for the HI/LO multiply/divide sequencer.
// Latency: n/a (definitions only). Backpressure: n/a.
package muldiv_sequencer_pkg;

  localparam logic [1:0] MD_OP_DIV   = 2'b00;
  localparam logic [1:0] MD_OP_DIVU  = 2'b01;
  localparam logic [1:0] MD_OP_MULT  = 2'b10;
  localparam logic [1:0] MD_OP_MULTU = 2'b11;

  localparam int MD_DIV_STEPS = 32;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_DIV_RUN = 2'd1,
    MD_MUL_RUN = 2'd2,
    MD_DONE    = 2'd3
  } md_state_t;

  // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the product are exact either way.
  function automatic logic [63:0] md_mul64(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{sgn & a[31]}}, a};
    bx = {{32{sgn & b[31]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [31:0] md_cneg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_iter_core.sv
// Restoring shift/subtract divider datapath on operand magnitudes, one quotient bit per step.
// Latency: 32 steps after load. Backpressure: none; the sequencer owns load/step timing.
module muldiv_sequencer_div_iter_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic [31:0] div_q;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        take;

  // Partial remainder shifted left with the next dividend bit pulled from the quotient register.
  assign shifted = {rem, quo[31]};
  assign take    = shifted >= {1'b0, div_q};
  assign diff    = shifted[31:0] - div_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo   <= '0;
      rem   <= '0;
      div_q <= '0;
    end else if (load) begin
      quo   <= a_mag;
      rem   <= '0;
      div_q <= b_mag;
    end else if (step) begin
      quo <= {quo[30:0], take};
      rem <= take ? diff : shifted[31:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage HI/LO mul/div sequencer: 32-step divide, optional sequenced multiply (MULDIV_MUL_SEQ_EN).
// Latency: divide 33 cycles accept-to-done, div-by-zero 1, multiply 0 (or MUL_LAT+1 when sequenced).
// Backpressure: stall_o holds the pipeline while running; DONE is held while stall_i is high.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int          MUL_LAT = 2,
  parameter logic [31:0] DIVZ_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        stall_i,
  input  logic        cancel_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = ($clog2(MUL_LAT) > 5) ? $clog2(MUL_LAT) : 5;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             is_div, is_sgn, a_neg, b_neg, accept, load, step;
  logic [31:0]      a_mag, b_mag, quo_mag, rem_mag, div_hi, div_lo;
  logic             q_neg_q, r_neg_q, divz_q, done_mul;
  logic [31:0]      hold_hi, hold_lo;
  logic [63:0]      mul_res;

  assign is_div = (op_i == MD_OP_DIV) | (op_i == MD_OP_DIVU);
  assign is_sgn = (op_i == MD_OP_DIV) | (op_i == MD_OP_MULT);
  assign a_neg  = is_sgn & a_i[31];
  assign b_neg  = is_sgn & b_i[31];
  assign a_mag  = md_cneg(a_i, a_neg);
  assign b_mag  = md_cneg(b_i, b_neg);
  assign accept = (state == MD_IDLE) & start_i & ~cancel_i;
  assign busy_o = (state != MD_IDLE);

  muldiv_sequencer_div_iter_core u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (load),
    .step   (step),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .quo    (quo_mag),
    .rem    (rem_mag)
  );

  // On divide-by-zero the core is loaded but never stepped, so quo_mag still holds |a|;
  // re-applying the dividend sign recovers the raw operand for HI.
  assign div_lo = divz_q ? DIVZ_LO : md_cneg(quo_mag, q_neg_q);
  assign div_hi = md_cneg(divz_q ? quo_mag : rem_mag, r_neg_q);

`ifdef MULDIV_MUL_SEQ_EN
  logic [31:0] mul_a_q, mul_b_q;
  logic        mul_sgn_q, is_mul_q;
  logic [63:0] prod_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_sgn_q <= 1'b0;
      is_mul_q  <= 1'b0;
      prod_q    <= '0;
    end else begin
      if (accept & ~is_div) begin
        mul_a_q   <= a_i;
        mul_b_q   <= b_i;
        mul_sgn_q <= is_sgn;
      end
      if (accept) is_mul_q <= ~is_div;
      prod_q <= md_mul64(mul_a_q, mul_b_q, mul_sgn_q);
    end
  end

  assign mul_res  = prod_q;
  assign done_mul = is_mul_q;
`else
  assign mul_res  = md_mul64(a_i, b_i, is_sgn);
  assign done_mul = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= MD_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    hi_o      = hold_hi;
    lo_o      = hold_lo;
    case (state)
      MD_IDLE: begin
        if (accept) begin
          if (is_div) begin
            load      = 1'b1;
            stall_o   = 1'b1;
            state_nxt = (b_i == '0) ? MD_DONE : MD_DIV_RUN;
          end else begin
`ifdef MULDIV_MUL_SEQ_EN
            stall_o   = 1'b1;
            state_nxt = MD_MUL_RUN;
`else
            done_o = 1'b1;
            hi_o   = mul_res[63:32];
            lo_o   = mul_res[31:0];
`endif
          end
        end
      end
      MD_DIV_RUN: begin
        stall_o = 1'b1;
        step    = 1'b1;
        if (cnt == CNT_W'(MD_DIV_STEPS - 1)) state_nxt = MD_DONE;
      end
      MD_MUL_RUN: begin
        stall_o = 1'b1;
        if (cnt == CNT_W'(MUL_LAT - 1)) state_nxt = MD_DONE;
      end
      MD_DONE: begin
        // A held start_i here is still the finishing instruction, so it never re-arms the op.
        if (!cancel_i) begin
          done_o = 1'b1;
          hi_o   = done_mul ? mul_res[63:32] : div_hi;
          lo_o   = done_mul ? mul_res[31:0]  : div_lo;
        end
        if (!stall_i) state_nxt = MD_IDLE;
      end
      default: state_nxt = MD_IDLE;
    endcase
    if (cancel_i) state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      divz_q  <= 1'b0;
      hold_hi <= '0;
      hold_lo <= '0;
    end else begin
      cnt <= (state == MD_IDLE) ? '0 : cnt + CNT_W'(1);
      if (load) begin
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        divz_q  <= (b_i == '0);
      end
      if (done_o) begin
        hold_hi <= hi_o;
        hold_lo <= lo_o;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: timing checked per scenario, results via a scoreboard queue.
module tb_muldiv_sequencer;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        stall_i = 1'b0;
  logic        cancel_i = 1'b0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  muldiv_sequencer #(.MUL_LAT(MUL_LAT), .DIVZ_LO(32'hFFFF_FFFF)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_i  (stall_i),
    .cancel_i (cancel_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every done cycle is compared with the oldest pending result; it retires once stall_i is low.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (resetn && done_o) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h with no result pending", hi_o, lo_o);
      end else begin
        e = exp_q[0];
        if ({hi_o, lo_o} !== e) begin
          errors++;
          $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, e[63:32], e[31:0]);
        end
        if (!stall_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [31:0] hi, input logic [31:0] lo);
    exp_q.push_back({hi, lo});
    last_hi = hi;
    last_lo = lo;
  endtask

  // Call at posedge+1; holds start until the done cycle, reports latency and stall cycles before done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int nstall, output logic dstall);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    lat = -1; nstall = 0; dstall = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        dstall = stall_o;
        break;
      end
      if (stall_o) nstall++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {stall_o, busy_o, done_o});
    end
    checks++;
    if ({hi_o, lo_o} !== 64'd0) begin
      errors++; $display("FAIL reset_hilo: got %h expected 0", {hi_o, lo_o});
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL idle_ctrl: got %b expected 000", {stall_o, busy_o, done_o});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    int lat, ns; logic ds;
    push(32'd2, 32'd14);
    run_op(2'b01, 32'd100, 32'd7, lat, ns, ds);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++;
    if (ns !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d expected 33", ns); end
    checks++;
    if (ds !== 1'b0) begin errors++; $display("FAIL divu_stall_at_done: got %b expected 0", ds); end
  endtask

  task automatic test_div_signed();
    int lat, ns; logic ds;
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, ns, ds);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_neg_latency: got %0d expected 33", lat); end
    push(32'd0, 32'h8000_0000);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, ns, ds);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_div_zero();
    int lat, ns; logic ds;
    push(32'd5, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd5, 32'd0, lat, ns, ds);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
    checks++;
    if (ns !== 1) begin errors++; $display("FAIL divz_stall_cycles: got %0d expected 1", ns); end
    push(32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, lat, ns, ds);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL divz_neg_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_mult();
    int lat, ns; logic ds;
    int exp_lat;
`ifdef MULDIV_MUL_SEQ_EN
    exp_lat = MUL_LAT + 1;
`else
    exp_lat = 0;
`endif
    push(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, lat, ns, ds);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", lat, exp_lat); end
    checks++;
    if (ns !== exp_lat) begin errors++; $display("FAIL mult_stall_cycles: got %0d expected %0d", ns, exp_lat); end
    push(32'd1, 32'hFFFF_FFFE);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2, lat, ns, ds);
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", lat, exp_lat); end
  endtask

  task automatic test_cancel();
    int lat, ns, d0; logic ds;
    // Cancel beats start in the same cycle.
    op_i = 2'b01; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL cancel_prio_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    cancel_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL cancel_prio_busy: got %b expected 0", busy_o); end
    @(posedge clk); #1;
    // Cancel at divide step 10.
    start_i = 1'b1;
    repeat (11) begin @(posedge clk); #1; end
    start_i = 1'b0; cancel_i = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, stall_o} !== 2'b00) begin errors++; $display("FAIL cancel_ctrl: got %b expected 00", {busy_o, stall_o}); end
    checks++;
    if ({hi_o, lo_o} !== {last_hi, last_lo}) begin
      errors++; $display("FAIL cancel_hilo: got %h expected %h", {hi_o, lo_o}, {last_hi, last_lo});
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL cancel_no_done: got %0d done cycles expected 0", done_cnt - d0); end
    push(32'd1, 32'd333);
    run_op(2'b01, 32'd1000, 32'd3, lat, ns, ds);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL after_cancel_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_done_stall();
    int lat, d0;
    push(32'd0, 32'd10);
    d0 = done_cnt;
    stall_i = 1'b1;
    op_i = 2'b01; a_i = 32'd50; b_i = 32'd5; start_i = 1'b1;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_o) begin lat = c; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL hold_latency: got %0d expected 33", lat); end
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b1) begin errors++; $display("FAIL hold_done: got %b expected 1", done_o); end
    end
    @(posedge clk); #1;
    stall_i = 1'b0;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin errors++; $display("FAIL hold_release_done: got %b expected 1", done_o); end
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin errors++; $display("FAIL hold_no_restart: got %b expected 00", {done_o, busy_o}); end
    @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 4) begin errors++; $display("FAIL hold_done_cycles: got %0d expected 4", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int lat, ns; logic ds;
    logic [1:0]  op;
    logic [31:0] a, b, eq, er;
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 1) ? 2'b01 : 2'b00;
      a  = $urandom;
      b  = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd1;
      if (op == 2'b01) begin
        eq = a / b;
        er = a % b;
      end else begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
        eq = 32'($signed(a) / $signed(b));
        er = 32'($signed(a) % $signed(b));
      end
      push(er, eq);
      run_op(op, a, b, lat, ns, ds);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 33", i, lat); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, ns; logic ds;
    op_i = 2'b01; a_i = 32'd77; b_i = 32'd5; start_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    start_i = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL midreset_ctrl: got %b expected 000", {stall_o, busy_o, done_o});
    end
    checks++;
    if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL midreset_hilo: got %h expected 0", {hi_o, lo_o}); end
    last_hi = '0; last_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    push(32'd2, 32'd15);
    run_op(2'b01, 32'd77, 32'd5, lat, ns, ds);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL after_reset_latency: got %0d expected 33", lat); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_mult();
    test_cancel();
    test_done_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
